// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multicycle MIPS-32 main control FSM.
//   ctrl_state_t   - 4-bit controller state; codes 12-15 are unused
//   OP_*           - instr[31:26] opcodes recognised in DECODE
//   ALU_OP_*       - alu_op encodings sent to the ALU decoder
//   SRC_B_*        - alu_src_b mux encodings
//   PC_SRC_*       - pc_src mux encodings
//   ctrl_word_t    - control word produced by multicycle_out_dec
//   is_legal_op()  - DECODE legality check; addi is legal only when
//                    MULTICYCLE_CTRL_ADDI_EN is defined
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBeq    = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_RD2     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_CTRL_ADDI_EN
        legal = legal || (op == OP_ADDI);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the main control FSM and the datapath.
//   Datapath -> controller: op (instr[31:26]), zero (ALU flag), mem_ready.
//   Controller -> datapath: PC/IR/memory/register-file enables, mux selects,
//   alu_op, debug state, instr_done and illegal_op pulses.
//   modport master: the controller; modport slave: the datapath side.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, i_or_d, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, i_or_d, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_out_dec.sv
// multicycle_out_dec: Moore output decoder for the multicycle control FSM.
//   i_state     - current controller state
//   i_mem_ready - memory handshake; gates FETCH load enables and MEMWR retirement
//   i_zero      - ALU zero flag; qualifies the branch PC load in BEQ
//   o_ctrl      - control word (reset gating is applied by the parent)
// ADDIEX/ADDIWB decode only when MULTICYCLE_CTRL_ADDI_EN is defined.
module multicycle_out_dec
    import multicycle_pkg::*;
(
    input  ctrl_state_t i_state,
    input  logic        i_mem_ready,
    input  logic        i_zero,
    output ctrl_word_t  o_ctrl
);

    logic w_pc_write;
    logic w_branch;

    always_comb begin
        o_ctrl     = '0;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;

        unique case (i_state)
            StFetch: begin
                o_ctrl.alu_src_b = SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_src    = PC_SRC_ALU;
                // Loads only on the ready cycle so a stalled fetch never double-loads
                o_ctrl.ir_write  = i_mem_ready;
                w_pc_write       = i_mem_ready;
            end
            StDecode: begin
                // Branch target precompute: PC+4 + (signimm<<2)
                o_ctrl.alu_src_b = SRC_B_IMM_SH2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            StMemAdr: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            StMemRd: begin
                o_ctrl.i_or_d = 1'b1;
            end
            StMemWb: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            StExec: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_RD2;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StBeq: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRC_B_RD2;
                o_ctrl.alu_op     = ALU_OP_SUB;
                o_ctrl.pc_src     = PC_SRC_ALUOUT;
                o_ctrl.instr_done = 1'b1;
                w_branch          = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            StAddiEx: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            StAddiWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
`endif
            StJump: begin
                o_ctrl.pc_src     = PC_SRC_JUMP;
                o_ctrl.instr_done = 1'b1;
                w_pc_write        = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase

        o_ctrl.pc_en = w_pc_write | (w_branch & i_zero);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS-32 datapath.
//   CLK  - clock, rising edge
//   rst  - synchronous active-low reset; loads FETCH and masks all strobes while low
//   bus  - multicycle_ctrl_if.master: op/zero/mem_ready in, control word,
//          debug state, instr_done and illegal_op out
// Optional feature macro: MULTICYCLE_CTRL_ADDI_EN (adds ADDIEX/ADDIWB for addi;
// otherwise addi decodes as illegal).
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic              CLK,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    ctrl_word_t  w_ctrl;
    logic        w_illegal;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;

        unique case (r_state)
            StFetch: begin
                if (bus.mem_ready) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (!is_legal_op(bus.op)) begin
                    w_state_next = StFetch;
                    w_illegal    = 1'b1;
                end else begin
                    case (bus.op)
                        OP_LW, OP_SW: w_state_next = StMemAdr;
                        OP_RTYPE:     w_state_next = StExec;
                        OP_BEQ:       w_state_next = StBeq;
                        OP_J:         w_state_next = StJump;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                        OP_ADDI:      w_state_next = StAddiEx;
`endif
                        default:      w_state_next = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                w_state_next = (bus.op == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                if (bus.mem_ready) begin
                    w_state_next = StMemWb;
                end
            end
            StMemWr: begin
                if (bus.mem_ready) begin
                    w_state_next = StFetch;
                end
            end
            StExec: begin
                w_state_next = StAluWb;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            StAddiEx: begin
                w_state_next = StAddiWb;
            end
`endif
            StMemWb, StAluWb, StBeq, StJump: begin
                w_state_next = StFetch;
            end
            // Unused codes (and removed addi states) recover to FETCH
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    multicycle_out_dec u_out_dec (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .i_zero      (bus.zero),
        .o_ctrl      (w_ctrl)
    );

    // Strobes are masked while reset is held so nothing loads mid-reset
    assign bus.pc_en      = rst & w_ctrl.pc_en;
    assign bus.ir_write   = rst & w_ctrl.ir_write;
    assign bus.mem_write  = rst & w_ctrl.mem_write;
    assign bus.reg_write  = rst & w_ctrl.reg_write;
    assign bus.instr_done = rst & w_ctrl.instr_done;
    assign bus.illegal_op = rst & w_illegal;

    assign bus.i_or_d     = w_ctrl.i_or_d;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.alu_src_a  = w_ctrl.alu_src_a;
    assign bus.alu_src_b  = w_ctrl.alu_src_b;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.pc_src     = w_ctrl.pc_src;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// Each step compares the full output vector
// {state, pc_en, i_or_d, ir_write, mem_write, mem_to_reg, reg_dst, reg_write,
//  alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op}
// against hand-written per-state values. Addi expectations follow
// MULTICYCLE_CTRL_ADDI_EN.
module tb_multicycle_ctrl;

    logic CLK = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    logic [19:0] obs;
    assign obs = {bus_if.state, bus_if.pc_en, bus_if.i_or_d, bus_if.ir_write,
                  bus_if.mem_write, bus_if.mem_to_reg, bus_if.reg_dst, bus_if.reg_write,
                  bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_src,
                  bus_if.instr_done, bus_if.illegal_op};

    function automatic logic [19:0] e(
        input logic [3:0] st, input logic pce, input logic iod, input logic irw,
        input logic mw, input logic m2r, input logic rdst, input logic rw,
        input logic sa, input logic [1:0] sb, input logic [1:0] aop,
        input logic [1:0] psrc, input logic done, input logic ill);
        return {st, pce, iod, irw, mw, m2r, rdst, rw, sa, sb, aop, psrc, done, ill};
    endfunction

    // Hand-written per-state expected vectors
    function automatic logic [19:0] x_fetch(input logic r);
        return e(4'd0, r, 0, r, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] x_decode(input logic ill);
        return e(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, ill);
    endfunction
    localparam logic [19:0] X_MEMADR = 20'b0010_0000000_1_10_00_00_0_0;
    localparam logic [19:0] X_MEMRD  = 20'b0011_0100000_0_00_00_00_0_0;
    localparam logic [19:0] X_MEMWB  = 20'b0100_0000101_0_00_00_00_1_0;
    localparam logic [19:0] X_EXEC   = 20'b0110_0000000_1_00_10_00_0_0;
    localparam logic [19:0] X_ALUWB  = 20'b0111_0000011_0_00_00_00_1_0;
    localparam logic [19:0] X_ADDIEX = 20'b1001_0000000_1_10_00_00_0_0;
    localparam logic [19:0] X_ADDIWB = 20'b1010_0000001_0_00_00_00_1_0;
    localparam logic [19:0] X_JUMP   = 20'b1011_1000000_0_00_00_10_1_0;
    // ALUWB with reset held: reg_write and instr_done masked
    localparam logic [19:0] X_ALUWB_RST = 20'b0111_0000010_0_00_00_00_0_0;
    function automatic logic [19:0] x_memwr(input logic r);
        return e(4'd5, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, r, 0);
    endfunction
    function automatic logic [19:0] x_beq(input logic z);
        return e(4'd8, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs checked 1 unit later
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic step(input string tag, input logic [19:0] exp);
        #1;
        chk(tag, exp);
        tick();
    endtask

    initial begin
        rst              = 1'b0;
        bus_if.op        = 6'b000000;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b1;

        // Reset: FETCH with strobes masked even though mem_ready=1
        tick();
        step("rst_fetch", x_fetch(1'b0));
        rst = 1'b1;

        // lw, zero wait: 0,1,2,3,4
        bus_if.op = 6'b100011;
        step("lw_fetch", x_fetch(1'b1));
        step("lw_decode", x_decode(1'b0));
        step("lw_memadr", X_MEMADR);
        step("lw_memrd", X_MEMRD);
        step("lw_memwb", X_MEMWB);

        // sw with 3 wait cycles in MEMWR: 7 cycles total
        bus_if.op = 6'b101011;
        step("sw_fetch", x_fetch(1'b1));
        step("sw_decode", x_decode(1'b0));
        step("sw_memadr", X_MEMADR);
        bus_if.mem_ready = 1'b0;
        step("sw_wait0", x_memwr(1'b0));
        step("sw_wait1", x_memwr(1'b0));
        step("sw_wait2", x_memwr(1'b0));
        bus_if.mem_ready = 1'b1;
        step("sw_memwr", x_memwr(1'b1));

        // R-type with 2 fetch wait cycles
        bus_if.op        = 6'b000000;
        bus_if.mem_ready = 1'b0;
        step("r_fwait0", x_fetch(1'b0));
        step("r_fwait1", x_fetch(1'b0));
        bus_if.mem_ready = 1'b1;
        step("r_fetch", x_fetch(1'b1));
        step("r_decode", x_decode(1'b0));
        step("r_exec", X_EXEC);
        step("r_aluwb", X_ALUWB);

        // beq taken / not taken
        bus_if.op   = 6'b000100;
        bus_if.zero = 1'b1;
        step("beq1_fetch", x_fetch(1'b1));
        step("beq1_decode", x_decode(1'b0));
        step("beq1_taken", x_beq(1'b1));
        bus_if.zero = 1'b0;
        step("beq0_fetch", x_fetch(1'b1));
        step("beq0_decode", x_decode(1'b0));
        step("beq0_not_taken", x_beq(1'b0));

        // addi
        bus_if.op = 6'b001000;
        step("addi_fetch", x_fetch(1'b1));
`ifdef MULTICYCLE_CTRL_ADDI_EN
        step("addi_decode", x_decode(1'b0));
        step("addi_ex", X_ADDIEX);
        step("addi_wb", X_ADDIWB);
`else
        step("addi_illegal", x_decode(1'b1));
`endif

        // j
        bus_if.op = 6'b000010;
        step("j_fetch", x_fetch(1'b1));
        step("j_decode", x_decode(1'b0));
        step("j_jump", X_JUMP);

        // illegal opcode: 2 cycles, then back in FETCH
        bus_if.op = 6'b111111;
        step("ill_fetch", x_fetch(1'b1));
        step("ill_decode", x_decode(1'b1));

        // Reset for one edge while stalled in MEMRD
        bus_if.op = 6'b100011;
        step("rmr_fetch", x_fetch(1'b1));
        step("rmr_decode", x_decode(1'b0));
        step("rmr_memadr", X_MEMADR);
        bus_if.mem_ready = 1'b0;
        step("rmr_memrd_wait", X_MEMRD);
        rst = 1'b0;
        step("rmr_memrd_rst", X_MEMRD);
        rst              = 1'b1;
        bus_if.mem_ready = 1'b1;
        step("rmr_after_rst", x_fetch(1'b1));

        // Reset while in ALUWB masks reg_write/instr_done, then FETCH
        bus_if.op = 6'b000000;
        step("rwb_decode", x_decode(1'b0));
        step("rwb_exec", X_EXEC);
        rst = 1'b0;
        step("rwb_aluwb_rst", X_ALUWB_RST);
        rst = 1'b1;
        step("rwb_after_rst", x_fetch(1'b1));

        // Reset while decoding an illegal opcode masks illegal_op
        bus_if.op = 6'b111111;
        rst       = 1'b0;
        step("rill_decode_rst", x_decode(1'b0));
        rst = 1'b1;
        step("rill_after_rst", x_fetch(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main control FSM that sequences a multicycle MIPS-32 datapath built from the existing register file, ALU, ALU decoder, shared instruction/data memory and PC register. It replaces the hand-driven control inputs of the single-cycle CPU top: it decodes `instr[31:26]`, steps each instruction through fetch/decode/execute/memory/writeback states, and drives every datapath mux select and register enable. Memory accesses stall on a ready handshake.

## Interface
- No parameters; all encodings are fixed in the package.
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `op` in 6: opcode, `instr[31:26]` from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `pc_en` out 1: PC register load enable, equal to `pc_write | (branch & zero)`.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALU out register.
- `ir_write` out 1: instruction register load.
- `mem_write` out 1: memory write strobe.
- `mem_to_reg` out 1: register-file write data select. 0 = ALU out, 1 = memory data.
- `reg_dst` out 1: write register select. 0 = `rt`, 1 = `rd`.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = `srcA`.
- `alu_src_b` out 2: ALU B select. 00 = `rd2`, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `alu_op` out 2: to the ALU decoder. 00 = add, 01 = sub, 10 = funct.
- `pc_src` out 2: next-PC select. 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the last cycle of each retired instruction.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused and go to FETCH on the next edge.
- FETCH:
  - Drives `i_or_d=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=00`, `pc_src=00`.
  - `ir_write` and `pc_write` are asserted only when `mem_ready=1`.
  - Holds in FETCH while `mem_ready=0`; goes to DECODE when it is 1.
- DECODE:
  - Drives `alu_src_a=0`, `alu_src_b=11`, `alu_op=00` (branch target precompute).
  - Next state by `op`: lw 100011 / sw 101011 → MEMADR; R-type 000000 → EXEC; beq 000100 → BEQ; addi 001000 → ADDIEX; j 000010 → JUMP.
  - Any other `op` → FETCH with `illegal_op=1`.
- MEMADR: drives `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: drives `i_or_d=1`. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: drives `reg_dst=0`, `mem_to_reg=1`, `reg_write=1`. Goes to FETCH.
- MEMWR: drives `i_or_d=1`, `mem_write=1`. Holds until `mem_ready`, then goes to FETCH.
- EXEC: drives `alu_src_a=1`, `alu_src_b=00`, `alu_op=10`. Goes to ALUWB.
- ALUWB: drives `reg_dst=1`, `mem_to_reg=0`, `reg_write=1`. Goes to FETCH.
- BEQ: drives `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_src=01`, `branch=1`. Goes to FETCH.
- ADDIEX: drives `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`. Goes to ADDIWB.
- ADDIWB: drives `reg_dst=0`, `mem_to_reg=0`, `reg_write=1`. Goes to FETCH.
- JUMP: drives `pc_src=10`, `pc_write=1`. Goes to FETCH.
- Any signal not listed for a state is driven to 0.
- `instr_done` is 1 in MEMWB, ALUWB, BEQ, ADDIWB and JUMP. It is 1 in MEMWR only when `mem_ready=1`.

## Timing
- All outputs are combinational from `state`; `mem_ready` gates only the outputs noted above. State updates on the `CLK` rising edge.
- Reset:
  - `rst=0` at an edge loads FETCH, including when it arrives mid-instruction.
  - While `rst=0`, `pc_en`, `ir_write`, `mem_write`, `reg_write`, `instr_done` and `illegal_op` are forced to 0.
  - After reset, `state=0` and all other outputs take their FETCH values.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each wait cycle (`mem_ready=0` in FETCH, MEMRD or MEMWR) adds one cycle. Enables stay low during waits, so no register double-loads.
- BEQ: `pc_en` follows `zero` combinationally within the same cycle.

## Configuration
- `MULTICYCLE_CTRL_ADDI_EN`:
  - Defined: ADDIEX and ADDIWB exist, and addi completes in 4 cycles.
  - Undefined: both states are removed and opcode 001000 is treated as illegal (DECODE → FETCH with `illegal_op` pulse).

## Structure
- Package `multicycle_pkg` holds:
  - the `ctrl_state_t` enum (4-bit);
  - opcode localparams (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`);
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- One sub-module, `multicycle_out_dec`: a combinational mapping from state, `mem_ready` and `zero` to the control word. The FSM register and next-state logic live in `multicycle_ctrl`.

## Test plan
- Reset mid-MEMRD with `rst=0` for 1 edge → `state=0`; all enables 0 during reset; FETCH values on the following cycle.
- `op=100011`, `mem_ready=1` → states 0,1,2,3,4 → 0. `reg_write=1` only in state 4; `instr_done` pulses once.
- `op=101011` with `mem_ready` low for 3 cycles in MEMWR → MEMWR holds 3 extra cycles with `mem_write=1`. `instr_done` fires only on the ready cycle; total 7 cycles.
- `op=000100`: with `zero=1`, BEQ gives `pc_en=1` and `pc_src=01`. With `zero=0`, `pc_en=0`; both cases take 3 cycles.
- `op=001000`: macro defined → states 0,1,9,10 with `reg_write` in 10. Macro undefined → 0,1,0 with `illegal_op=1` in DECODE.
- `op=000010` → states 0,1,11 with `pc_en=1` and `pc_src=10`. `op=111111` → `illegal_op` pulse, no write enables asserted.
